// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: a request/grant/response bus master that stalls the core until each access retires.
// Optional build macro LSU_MISALIGN_CHECK_EN retires misaligned half/word accesses without a bus cycle and flags them on misalign.
module lsu_mem_stage #(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_RDATA = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    input  logic              mem_wr,
    input  logic              mem_rd,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        op_q, op_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              start;
    logic [1:0]        lane;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;
    logic [3:0]        strb;

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic bad_align;

    // op[1:0]=01 is a half access, op[1]=1 is a word access (including 011/110/111).
    assign bad_align = ((mem_op[1:0] == 2'b01) && addr[0]) ||
                       (mem_op[1] && (addr[1:0] != 2'b00));
    assign misalign  = misalign_q;
`endif

    assign start = inst_valid & (mem_wr | mem_rd);
    assign lane  = addr_q[1:0];

    always_comb begin
        ld_byte = 8'h00;
        case (lane)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        case (op_q[1:0])
            2'b00: begin
                strb      = 4'b0001 << lane;
                mem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb      = lane[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                mem_wdata = wdata_q;
            end
        endcase
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        we_d    = we_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_d    = mem_op;
                    we_d    = mem_wr;
`ifdef LSU_MISALIGN_CHECK_EN
                    if (bad_align) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                        rdata_d    = 32'h0;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = ld_ext;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the latched request fields are reset too, so the bus outputs derived from them read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            op_q    <= 3'b000;
            we_q    <= 1'b0;
            rdata_q <= RESET_RDATA;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wstrb = mem_we ? strb : 4'b0000;
    assign done      = (state_q == S_DONE);
    // Combinational so the very first cycle of an access already holds the PC.
    assign stall     = start & ~done;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: inputs change on the falling edge, outputs are checked 1ns later.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, mem_wr, mem_rd;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata;
    logic        stall, done, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    lsu_mem_stage #(.ADDR_W(32), .RESET_RDATA(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst_valid(inst_valid),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_op    (mem_op),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
`ifdef LSU_MISALIGN_CHECK_EN
        ,
        .misalign  (misalign)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_valid = 1'b0;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    // One full access. gnt_dly = REQ cycles before the grant cycle; rv_dly = cycles after grant until rvalid (loads, >=1).
    task automatic run_access(input string tag, input logic wr, input logic also_rd, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] wd, input int gnt_dly,
                              input int rv_dly, input logic [31:0] rd, input logic [31:0] exp_rdata,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        logic [31:0] exp_addr;
        exp_addr = {a[31:2], 2'b00};
        @(negedge clk);
        inst_valid = 1'b1;
        mem_wr     = wr;
        mem_rd     = ~wr | also_rd;
        mem_op     = op;
        addr       = a;
        wdata      = wd;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check({tag, " idle stall"}, stall, 1);
        check({tag, " idle req"}, mem_req, 0);
        for (int i = 0; i <= gnt_dly; i++) begin
            @(negedge clk);
            mem_gnt    = (i == gnt_dly);
            mem_rvalid = (i < gnt_dly);
            mem_rdata  = 32'h0BAD0BAD;
            #1;
            check({tag, " req"}, mem_req, 1);
            check({tag, " req addr"}, mem_addr, exp_addr);
            check({tag, " req we"}, mem_we, wr);
            check({tag, " req strb"}, mem_wstrb, exp_strb);
            check({tag, " req stall"}, stall, 1);
            if (wr) check({tag, " req wdata"}, mem_wdata, exp_wdata);
        end
        if (!wr) begin
            for (int i = 1; i <= rv_dly; i++) begin
                @(negedge clk);
                mem_gnt    = 1'b0;
                mem_rvalid = (i == rv_dly);
                mem_rdata  = (i == rv_dly) ? rd : 32'h0BAD0BAD;
                #1;
                check({tag, " wait req"}, mem_req, 0);
                check({tag, " wait stall"}, stall, 1);
                check({tag, " wait done"}, done, 0);
            end
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check({tag, " done"}, done, 1);
        check({tag, " done stall"}, stall, 0);
        check({tag, " done req"}, mem_req, 0);
        if (!wr) check({tag, " rdata"}, rdata, exp_rdata);
`ifdef LSU_MISALIGN_CHECK_EN
        check({tag, " misalign"}, misalign, 0);
`endif
        @(negedge clk);
        idle_inputs();
        #1;
        check({tag, " done once"}, done, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        mem_op = 3'b000;
        addr   = 32'h0;
        wdata  = 32'h0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst req", mem_req, 0);
        check("rst we", mem_we, 0);
        check("rst strb", mem_wstrb, 0);
        check("rst addr", mem_addr, 0);
        check("rst wdata", mem_wdata, 0);
        check("rst done", done, 0);
        check("rst rdata", rdata, 0);
        check("rst stall", stall, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("rst misalign", misalign, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        //          tag     wr  both op      addr          wdata         g  r  rdata          exp_rdata      strb     wdata
        run_access("sw",    1, 0, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        4'b1111, 32'hDEADBEEF);
        run_access("sb",    1, 0, 3'b000, 32'h0000_0103, 32'h000000A5, 0, 0, 32'h0,        32'h0,        4'b1000, 32'hA5A5A5A5);
        run_access("sh",    1, 0, 3'b001, 32'h0000_0106, 32'h1234BEEF, 1, 0, 32'h0,        32'h0,        4'b1100, 32'hBEEFBEEF);
        run_access("sb+rd", 1, 1, 3'b000, 32'h0000_0201, 32'h0000003C, 0, 0, 32'h0,        32'h0,        4'b0010, 32'h3C3C3C3C);
        run_access("lb",    0, 0, 3'b000, 32'h0000_0202, 32'h0,        0, 1, 32'h12803456, 32'hFFFFFF80, 4'b0000, 32'h0);
        run_access("lbu",   0, 0, 3'b100, 32'h0000_0202, 32'h0,        0, 1, 32'h12803456, 32'h00000080, 4'b0000, 32'h0);
        run_access("lhu",   0, 0, 3'b101, 32'h0000_0202, 32'h0,        0, 1, 32'h12803456, 32'h00001280, 4'b0000, 32'h0);
        run_access("lh",    0, 0, 3'b001, 32'h0000_0200, 32'h0,        0, 1, 32'h0000F00D, 32'hFFFFF00D, 4'b0000, 32'h0);
        run_access("lw",    0, 0, 3'b010, 32'h0000_0300, 32'h0,        3, 2, 32'hCAFEF00D, 32'hCAFEF00D, 4'b0000, 32'h0);
        run_access("l111",  0, 0, 3'b111, 32'h0000_0304, 32'h0,        0, 1, 32'h87654321, 32'h87654321, 4'b0000, 32'h0);

`ifdef LSU_MISALIGN_CHECK_EN
        @(negedge clk);
        inst_valid = 1'b1;
        mem_rd     = 1'b1;
        mem_op     = 3'b010;
        addr       = 32'h0000_0102;
        #1;
        check("mis idle req", mem_req, 0);
        check("mis idle stall", stall, 1);
        @(negedge clk);
        #1;
        check("mis done", done, 1);
        check("mis flag", misalign, 1);
        check("mis rdata", rdata, 0);
        check("mis req", mem_req, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mis clear", misalign, 0);
        run_access("lh ok", 0, 0, 3'b001, 32'h0000_0102, 32'h0, 0, 1, 32'h8001_7FFE, 32'hFFFF8001, 4'b0000, 32'h0);
`else
        run_access("lw mis", 0, 0, 3'b010, 32'h0000_0102, 32'h0, 0, 1, 32'h13579BDF, 32'h13579BDF, 4'b0000, 32'h0);
        run_access("lh mis", 0, 0, 3'b001, 32'h0000_0103, 32'h0, 0, 1, 32'h8001_7FFE, 32'hFFFF8001, 4'b0000, 32'h0);
`endif

        // Reset while waiting for read data; the late rvalid must be dropped.
        @(negedge clk);
        inst_valid = 1'b1;
        mem_rd     = 1'b1;
        mem_op     = 3'b010;
        addr       = 32'h0000_0400;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rstw stall", stall, 1);
        check("rstw req", mem_req, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        #1;
        check("rstw req after", mem_req, 0);
        check("rstw done after", done, 0);
        check("rstw rdata", rdata, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            #1;
            check("rstw no done", done, 0);
            check("rstw rdata hold", rdata, 0);
        end
        run_access("sw2", 1, 0, 3'b110, 32'h0000_0504, 32'h01020304, 0, 0, 32'h0, 32'h0, 4'b1111, 32'h01020304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
